// File: rtl/countdown_display.sv
`default_nettype none
// ============================================================================
// Module  : countdown_display
// Brief   : Drives a 4-digit common-anode multiplexed 7-segment display from a
//           5-bit seconds count. Optional blink: define COUNTDOWN_BLINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module countdown_display #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] value,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_DIV = CLK_HZ / REFRESH_HZ;
  localparam int DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);

  logic [4:0]       r_value_q;
  logic             r_en_q;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic             w_scan_tick;
  logic [1:0]       w_tens;
  logic [3:0]       w_ones;
  logic             w_blink_dark;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;

  assign w_scan_tick = (r_div_cnt == c_div_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value_q   <= 5'd0;
      r_en_q      <= 1'b0;
      r_div_cnt   <= '0;
      r_digit_idx <= 2'd0;
    end else begin
      r_value_q <= value;
      r_en_q    <= enable;
      if (w_scan_tick) begin
        r_div_cnt   <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + c_div_one;
      end
    end
  end

  // Value never exceeds 31, so three compare/subtract steps cover every tens digit.
  always_comb begin
    w_tens = 2'd0;
    w_ones = r_value_q[3:0];
    if (r_value_q >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = 4'(r_value_q - 5'd30);
    end else if (r_value_q >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = 4'(r_value_q - 5'd20);
    end else if (r_value_q >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = 4'(r_value_q - 5'd10);
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

`ifdef COUNTDOWN_BLINK_EN
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK_DIV - 1);
  localparam logic [BLINK_W-1:0] c_blink_one  = BLINK_W'(1);

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_on;

  // Free-running half-period counter; value changes never restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + c_blink_one;
    end
  end

  assign w_blink_dark = !r_blink_on && (r_value_q != 5'd0) && (r_value_q <= 5'd5);
`else
  logic w_blink_hz_unused;
  assign w_blink_hz_unused = (BLINK_HZ != 0);
  assign w_blink_dark      = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = 4'b1111;
    w_seg_nxt = 7'b1111111;
    if (r_en_q && !w_blink_dark) begin
      case (r_digit_idx)
        2'd0: begin
          w_an_nxt  = 4'b1110;
          w_seg_nxt = glyph(w_ones);
        end
        2'd1: begin
          if (w_tens != 2'd0) begin
            w_an_nxt  = 4'b1101;
            w_seg_nxt = glyph({2'b00, w_tens});
          end
        end
        default: begin
          w_an_nxt  = 4'b1111;
          w_seg_nxt = 7'b1111111;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_countdown_display.sv
`default_nettype none
// Bench for countdown_display: vector table, hand-written corner sequences and
// random stimulus checked every cycle against an arithmetic pin model.
module tb_countdown_display;

  localparam int CLK_HZ     = 1000;
  localparam int REFRESH_HZ = 100;
  localparam int BLINK_HZ   = 10;
  localparam int SLOT       = CLK_HZ / REFRESH_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [4:0] value  = 5'd0;
  logic       enable = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  countdown_display #(
    .CLK_HZ    (CLK_HZ),
    .REFRESH_HZ(REFRESH_HZ),
    .BLINK_HZ  (BLINK_HZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .enable(enable),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int hv[$];
  int he[$];

  logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  typedef struct {
    int         val;
    int         en;
    logic [3:0] an0;
    logic [6:0] seg0;
    logic [3:0] an1;
    logic [6:0] seg1;
  } vec_t;
  vec_t vecs[$];

  // Pins after edge k: registered inputs of edge k-1, slot of edge k-1.
  function automatic logic [11:0] model(input int k);
    int v, e, slot;
    bit dark;
    logic [3:0] a;
    logic [6:0] s;
    a = 4'b1111;
    s = 7'b1111111;
    if (k >= 1) begin
      v    = hv[k-1];
      e    = he[k-1];
      slot = ((k - 1) / SLOT) % 4;
      dark = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
      if (v >= 1 && v <= 5 && (((k - 1) / BLINK_HALF) % 2) == 1) dark = 1'b1;
`endif
      if (e != 0 && !dark) begin
        if (slot == 0) begin
          a = 4'b1110;
          s = glyph_tab[v % 10];
        end else if (slot == 1 && (v / 10) != 0) begin
          a = 4'b1101;
          s = glyph_tab[v / 10];
        end
      end
    end
    return {a, s, 1'b1};
  endfunction

  function automatic logic [11:0] pins();
    return {an, seg, dp};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (n=%0d): got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, n, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    value  = 5'd30;
    enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", pins(), 12'hFFF);
    end
    hv.delete();
    he.delete();
    hv.push_back(0);
    he.push_back(0);
    n     = 0;
    rst_n = 1'b1;
  endtask

  task automatic tick(input int v, input int e);
    value  = 5'(v);
    enable = e[0];
    @(posedge clk);
    n++;
    hv.push_back(v);
    he.push_back(e);
    @(negedge clk);
    chk("model", pins(), model(n));
  endtask

  initial begin
    int v, e;

    vecs.push_back(vec_t'{30, 1, 4'b1110, 7'b1000000, 4'b1101, 7'b0110000});
    vecs.push_back(vec_t'{7,  1, 4'b1110, 7'b1111000, 4'b1111, 7'b1111111});
    vecs.push_back(vec_t'{0,  1, 4'b1110, 7'b1000000, 4'b1111, 7'b1111111});
    vecs.push_back(vec_t'{29, 1, 4'b1110, 7'b0010000, 4'b1101, 7'b0100100});
    vecs.push_back(vec_t'{15, 1, 4'b1110, 7'b0010010, 4'b1101, 7'b1111001});
    vecs.push_back(vec_t'{31, 1, 4'b1110, 7'b1111001, 4'b1101, 7'b0110000});
    vecs.push_back(vec_t'{24, 1, 4'b1110, 7'b0011001, 4'b1101, 7'b0100100});
    vecs.push_back(vec_t'{18, 0, 4'b1111, 7'b1111111, 4'b1111, 7'b1111111});

    foreach (vecs[i]) begin
      do_reset();
      for (int c = 1; c <= 40; c++) begin
        tick(vecs[i].val, vecs[i].en);
        if (c == 5 || c == 10)  chk("tbl_slot0", pins(), {vecs[i].an0, vecs[i].seg0, 1'b1});
        if (c == 11 || c == 20) chk("tbl_slot1", pins(), {vecs[i].an1, vecs[i].seg1, 1'b1});
        if (c == 21 || c == 25 || c == 35) chk("tbl_blank", pins(), 12'hFFF);
      end
    end

    // Asynchronous reset while slot 0 is lit.
    do_reset();
    repeat (5) tick(30, 1);
    chk("pre_async_reset", pins(), {4'b1110, 7'b1000000, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("async_reset", pins(), 12'hFFF);

    // Enable drop mid-slot 0, restore after 15 cycles.
    do_reset();
    tick(12, 1);
    tick(12, 1);
    tick(12, 0);
    chk("en_drop_1edge", pins(), {4'b1110, 7'b0100100, 1'b1});
    tick(12, 0);
    chk("en_drop_2edge", pins(), 12'hFFF);
    for (int c = 5; c <= 17; c++) tick(12, 0);
    tick(12, 1);
    chk("en_restore_1edge", pins(), 12'hFFF);
    tick(12, 1);
    chk("en_resume_slot1", pins(), {4'b1101, 7'b1111001, 1'b1});

    // Value change 29 -> 28 at cycle 3 of slot 0.
    do_reset();
    tick(29, 1);
    tick(29, 1);
    tick(28, 1);
    chk("mid_old_glyph", pins(), {4'b1110, 7'b0010000, 1'b1});
    tick(28, 1);
    chk("mid_new_glyph", pins(), {4'b1110, 7'b0000000, 1'b1});
    for (int c = 5; c <= 10; c++) tick(28, 1);
    chk("mid_slot_end", pins(), {4'b1110, 7'b0000000, 1'b1});
    tick(28, 1);
    chk("mid_next_slot", pins(), {4'b1101, 7'b0100100, 1'b1});

    // Blink window for value 5; value 6 is always steady.
    do_reset();
    for (int c = 1; c <= 130; c++) begin
      tick(5, 1);
      if (c == 5)   chk("blink5_lit_a", pins(), {4'b1110, 7'b0010010, 1'b1});
`ifdef COUNTDOWN_BLINK_EN
      if (c == 85)  chk("blink5_dark", pins(), 12'hFFF);
`else
      if (c == 85)  chk("blink5_steady", pins(), {4'b1110, 7'b0010010, 1'b1});
`endif
      if (c == 125) chk("blink5_lit_b", pins(), {4'b1110, 7'b0010010, 1'b1});
    end
    do_reset();
    for (int c = 1; c <= 90; c++) begin
      tick(6, 1);
      if (c == 85) chk("blink6_steady", pins(), {4'b1110, 7'b0000010, 1'b1});
    end

    // Random stimulus against the model.
    do_reset();
    v = 30;
    e = 1;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 31));
      e = ($urandom_range(0, 9) != 0) ? 1 : 0;
      tick(v, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
